shift_pattern_gen_param: RTL and testbench



---
 rtl/shift_pattern_gen_param.sv | 100 ++++++++++
 tb/tb_shift_pattern_gen_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_pattern_gen_param.sv
// WIDTH-bit pattern generator: rotate-left, rotate-right, ping-pong or Galois LFSR,
// advanced by a programmable prescaler, with step/wrap status pulses.
//
// state      | meaning
// DIR_LEFT   | ping-pong currently moving toward the MSB (rotate-left)
// DIR_RIGHT  | ping-pong currently moving toward the LSB (rotate-right)
module shift_pattern_gen_param #(
  parameter int unsigned           WIDTH = 3,
  parameter int unsigned           DIV_W = 27,
  parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(3'b110)
) (
  input  logic             clk_in1,
  input  logic             ext_reset_in,
  input  logic [WIDTH-1:0] first_value,
  input  logic             load,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] top_led_o,
  output logic             step_o,
  output logic             wrap_o
);

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

  logic [WIDTH-1:0] top_led_q;
  logic [WIDTH-1:0] start_q;
  logic [DIV_W-1:0] presc_q;
  dir_e             dir_q;
  dir_e             dir_d;
  logic             step_q;
  logic             wrap_q;

  logic [WIDTH-1:0] pat_rl;
  logic [WIDTH-1:0] pat_rr;
  logic [WIDTH-1:0] top_led_d;
  logic             tick;

  assign pat_rl = {top_led_q[WIDTH-2:0], top_led_q[WIDTH-1]};
  assign pat_rr = {top_led_q[0], top_led_q[WIDTH-1:1]};
  // Live div compare: a presc already past div must wrap around before ticking.
  assign tick   = enable && (presc_q == div);

  always_comb begin
    top_led_d = pat_rl;
    dir_d     = dir_q;
    case (mode)
      2'b00: top_led_d = pat_rl;
      2'b01: top_led_d = pat_rr;
      2'b10: begin
        if ((dir_q == DIR_LEFT) && top_led_q[WIDTH-1]) begin
          top_led_d = pat_rr;
          dir_d     = DIR_RIGHT;
        end else if ((dir_q == DIR_RIGHT) && top_led_q[0]) begin
          top_led_d = pat_rl;
          dir_d     = DIR_LEFT;
        end else begin
          top_led_d = (dir_q == DIR_LEFT) ? pat_rl : pat_rr;
        end
      end
      default: begin
        if (top_led_q == '0) begin
          top_led_d = WIDTH'(1);
        end else begin
          top_led_d = (top_led_q >> 1) ^ (top_led_q[0] ? TAPS : '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!ext_reset_in || load) begin
      top_led_q <= first_value;
      start_q   <= first_value;
      presc_q   <= '0;
      dir_q     <= DIR_LEFT;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (tick) begin
        presc_q   <= '0;
        top_led_q <= top_led_d;
        step_q    <= 1'b1;
        wrap_q    <= (top_led_d == start_q);
        if (mode == 2'b10) begin
          dir_q <= dir_d;
        end
      end else if (enable) begin
        presc_q <= presc_q + DIV_W'(1);
      end
    end
  end

  assign top_led_o = top_led_q;
  assign step_o    = step_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_shift_pattern_gen_param.sv
// Bench for shift_pattern_gen_param: directed sequences plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_shift_pattern_gen_param;
  localparam int W    = 3;
  localparam int DW   = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int TAPS = 3'b110;

  logic          clk_in1 = 1'b0;
  logic          ext_reset_in;
  logic [W-1:0]  first_value;
  logic          load;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [W-1:0]  top_led_o;
  logic          step_o;
  logic          wrap_o;

  shift_pattern_gen_param #(.WIDTH(W), .DIV_W(DW), .TAPS(3'b110)) dut (
    .clk_in1(clk_in1), .ext_reset_in(ext_reset_in), .first_value(first_value),
    .load(load), .enable(enable), .mode(mode), .div(div),
    .top_led_o(top_led_o), .step_o(step_o), .wrap_o(wrap_o)
  );

  always #5 clk_in1 = ~clk_in1;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pat, m_start, m_presc, m_dir, m_step, m_wrap;

  int exp_rl[3]   = '{3'b101, 3'b011, 3'b110};
  int exp_pp[5]   = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
  int exp_lfsr[7] = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_of(input int p, input int md, inout int dir);
    int rl, rr;
    rl = ((p << 1) | (p >> (W - 1))) & MASK;
    rr = (p >> 1) | ((p & 1) << (W - 1));
    case (md)
      0: return rl;
      1: return rr;
      2: begin
        if (dir == 0 && p >= (1 << (W - 1))) begin dir = 1; return rr; end
        if (dir == 1 && (p % 2) == 1)        begin dir = 0; return rl; end
        return (dir == 0) ? rl : rr;
      end
      default: begin
        if (p == 0) return 1;
        return (p >> 1) ^ (((p & 1) == 1) ? TAPS : 0);
      end
    endcase
  endfunction

  task automatic model_edge();
    if (!ext_reset_in || load) begin
      m_pat = first_value; m_start = first_value;
      m_presc = 0; m_dir = 0; m_step = 0; m_wrap = 0;
    end else begin
      m_step = 0; m_wrap = 0;
      if (enable) begin
        if (m_presc == int'(div)) begin
          int d;
          d = m_dir;
          m_pat   = next_of(m_pat, int'(mode), d);
          if (mode == 2'b10) m_dir = d;
          m_presc = 0;
          m_step  = 1;
          m_wrap  = (m_pat == m_start) ? 1 : 0;
        end else begin
          m_presc = (m_presc + 1) % (1 << DW);
        end
      end
    end
  endtask

  task automatic step_cycle();
    model_edge();
    @(posedge clk_in1);
    #1;
    check("pattern", int'(top_led_o), m_pat);
    check("step", int'(step_o), m_step);
    check("wrap", int'(wrap_o), m_wrap);
  endtask

  task automatic cycles_to_step(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      step_cycle();
      n++;
      if (step_o) return;
    end
    check("step_timeout", 0, 1);
  endtask

  task automatic do_load(input int seed);
    first_value = W'(seed); load = 1'b1;
    step_cycle();
    load = 1'b0;
  endtask

  initial begin
    int n, k, wraps;
    ext_reset_in = 1'b0; load = 1'b0; enable = 1'b0;
    mode = 2'b00; div = '0; first_value = 3'b110;
    step_cycle();
    step_cycle();
    check("reset_pat", int'(top_led_o), 3'b110);
    check("reset_step", int'(step_o), 0);

    ext_reset_in = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check("rl_seq", int'(top_led_o), exp_rl[i]);
      check("rl_stepped", int'(step_o), 1);
      check("rl_wrap", int'(wrap_o), (i == 2) ? 1 : 0);
    end

    mode = 2'b10;
    do_load(3'b001);
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      check("pp_seq", int'(top_led_o), exp_pp[i]);
    end

    mode = 2'b11;
    do_load(3'b001);
    wraps = 0;
    for (int i = 0; i < 14; i++) begin
      step_cycle();
      check("lfsr_seq", int'(top_led_o), exp_lfsr[i % 7]);
      wraps += int'(wrap_o);
    end
    check("lfsr_wraps", wraps, 2);
    do_load(3'b000);
    step_cycle();
    check("lfsr_escape", int'(top_led_o), 3'b001);

    mode = 2'b01; div = 4'd4;
    do_load(3'b100);
    cycles_to_step(n);
    check("period_first", n, 5);
    check("period_pat", int'(top_led_o), 3'b010);
    cycles_to_step(n);
    check("period_next", n, 5);
    step_cycle(); step_cycle();
    enable = 1'b0;
    step_cycle(); step_cycle(); step_cycle();
    enable = 1'b1;
    cycles_to_step(k);
    check("period_stretched", 5 + k, 8);
    check("period_wrap_pat", int'(top_led_o), 3'b100);
    check("period_wrap_flag", int'(wrap_o), 1);

    div = 4'd0; mode = 2'b00;
    step_cycle();
    first_value = 3'b011; load = 1'b1;
    step_cycle();
    load = 1'b0;
    check("load_on_tick_pat", int'(top_led_o), 3'b011);
    check("load_on_tick_step", int'(step_o), 0);

    first_value = 3'b101; ext_reset_in = 1'b0; load = 1'b1;
    step_cycle();
    ext_reset_in = 1'b1; load = 1'b0;
    check("rst_load_pat", int'(top_led_o), 3'b101);
    check("rst_load_step", int'(step_o), 0);
    check("rst_load_wrap", int'(wrap_o), 0);

    mode = 2'b01; div = 4'd10;
    do_load(3'b100);
    for (int i = 0; i < 7; i++) step_cycle();
    check("div_chg_presc", m_presc, 7);
    div = 4'd2;
    cycles_to_step(n);
    check("div_chg_wrap", n, 12);

    for (int i = 0; i < 3000; i++) begin
      ext_reset_in = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      load         = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
      enable       = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
      first_value  = W'($urandom);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 39) == 0) div = DW'($urandom_range(0, 5));
      step_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
